// File: rtl/fetch_pkg.sv
// -----------------------------------------------------------------------------
// fetch_pkg
//   Shared types and constants for the instruction fetch stage.
//   - fetch_state_t : fetch FSM states (running / parked on a misaligned target)
//   - if_id_t       : contents of the IF/ID pipeline register
//   - NOP_INSTR     : canonical NOP (addi x0, x0, 0) shown when IF/ID is empty
//   - is_misaligned : true when a target PC is not word aligned
// -----------------------------------------------------------------------------
package fetch_pkg;

  // Width that the IF/ID register type is built for.
  localparam int unsigned PKG_XLEN = 32;

  localparam logic [PKG_XLEN-1:0] NOP_INSTR        = 32'h0000_0013;
  localparam logic [PKG_XLEN-1:0] DEFAULT_RESET_PC = 32'h0000_0000;

  typedef enum logic {
    S_RUN   = 1'b0,
    S_FAULT = 1'b1
  } fetch_state_t;

  typedef struct packed {
    logic [PKG_XLEN-1:0] instr;
    logic [PKG_XLEN-1:0] pc;
    logic [PKG_XLEN-1:0] pc_plus4;
    logic                valid;
  } if_id_t;

  // Instructions are word sized, so any set bit in [1:0] is a bad target.
  function automatic logic is_misaligned(input logic [1:0] pc_lsb);
    return (pc_lsb != 2'b00);
  endfunction

endpackage

// File: rtl/fetch_hold_buffer.sv
// -----------------------------------------------------------------------------
// fetch_hold_buffer
//   One-entry skid register. Catches the memory response that arrives while
//   decode is stalled, because the request for it left a cycle before the
//   stall was seen.
//   Ports:
//     clk_i, rst_ni   clock, synchronous active-low reset
//     clear_i         drop any held entry (redirect); wins over load
//     load_i          capture instr_i/pc_i, mark entry valid
//     unload_i        entry was moved into IF/ID, mark empty
//     instr_i, pc_i   entry to capture
//     hold_valid_o    entry present
//     instr_o, pc_o   held entry
// -----------------------------------------------------------------------------
module fetch_hold_buffer #(
  parameter int unsigned XLEN = 32
) (
  input  logic            clk_i,
  input  logic            rst_ni,
  input  logic            clear_i,
  input  logic            load_i,
  input  logic            unload_i,
  input  logic [XLEN-1:0] instr_i,
  input  logic [XLEN-1:0] pc_i,
  output logic            hold_valid_o,
  output logic [XLEN-1:0] instr_o,
  output logic [XLEN-1:0] pc_o
);

  logic            valid_q, valid_d;
  logic [XLEN-1:0] instr_q, instr_d;
  logic [XLEN-1:0] pc_q,    pc_d;

  always_comb begin
    valid_d = valid_q;
    instr_d = instr_q;
    pc_d    = pc_q;
    if (clear_i) begin
      valid_d = 1'b0;
    end else if (load_i) begin
      valid_d = 1'b1;
      instr_d = instr_i;
      pc_d    = pc_i;
    end else if (unload_i) begin
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      valid_q <= 1'b0;
      instr_q <= '0;
      pc_q    <= '0;
    end else begin
      valid_q <= valid_d;
      instr_q <= instr_d;
      pc_q    <= pc_d;
    end
  end

  assign hold_valid_o = valid_q;
  assign instr_o      = instr_q;
  assign pc_o         = pc_q;

endmodule

// File: rtl/fetch_unit.sv
// -----------------------------------------------------------------------------
// fetch_unit
//   Instruction fetch stage feeding the decoder. Keeps the fetch PC, issues one
//   word request per cycle to a 1-cycle-latency synchronous instruction memory
//   and registers each returned instruction with its PC and PC+4 into IF/ID.
//
//   Handshake: imem_req_o/imem_addr_o form a request in the cycle they are
//   high; imem_rdata_i carries the answer exactly one cycle later and has no
//   valid of its own. The decoder consumes IF/ID in every cycle where
//   valid_o=1 and stall_i=0; with stall_i=1 IF/ID is held unchanged.
//
//   Ports:
//     clk_i, rst_ni        clock, synchronous active-low reset
//     stall_i              decode cannot accept, hold IF/ID
//     redirect_i           taken branch/jump, flush fetched work
//     redirect_pc_i        redirect target
//     imem_req_o           memory read request
//     imem_addr_o          request address (the fetch PC)
//     imem_rdata_i         data for last cycle's request
//     instr_o, pc_o        IF/ID instruction and its PC (NOP when invalid)
//     pc_plus4_o           pc_o + 4
//     valid_o              IF/ID holds a real instruction
//     misaligned_o         parked on a misaligned redirect target
// -----------------------------------------------------------------------------
module fetch_unit
  import fetch_pkg::*;
#(
  parameter int unsigned     XLEN     = 32,
  parameter logic [XLEN-1:0] RESET_PC = DEFAULT_RESET_PC
) (
  input  logic            clk_i,
  input  logic            rst_ni,
  input  logic            stall_i,
  input  logic            redirect_i,
  input  logic [XLEN-1:0] redirect_pc_i,
  output logic            imem_req_o,
  output logic [XLEN-1:0] imem_addr_o,
  input  logic [XLEN-1:0] imem_rdata_i,
  output logic [XLEN-1:0] instr_o,
  output logic [XLEN-1:0] pc_o,
  output logic [XLEN-1:0] pc_plus4_o,
  output logic            valid_o,
  output logic            misaligned_o
);

  localparam logic [XLEN-1:0] PC_INC = XLEN'(4);

  // IF/ID contents right after reset: empty slot showing a NOP at PC 0.
  localparam if_id_t IF_ID_RESET = '{
    instr:    NOP_INSTR,
    pc:       '0,
    pc_plus4: PC_INC,
    valid:    1'b0
  };

  fetch_state_t    state_q, state_d;
  logic [XLEN-1:0] fpc_q, fpc_d;
  logic [XLEN-1:0] req_pc_q, req_pc_d;     // PC whose data arrives this cycle
  logic            inflight_q, inflight_d; // imem_rdata_i is meaningful
  if_id_t          if_id_q, if_id_d;
  logic            misaligned_q, misaligned_d;

  logic            hb_load, hb_unload, hb_clear;
  logic            hold_valid;
  logic [XLEN-1:0] hold_instr, hold_pc;
  logic            req;

  // Redirect and stall both suppress the request: a redirect means fpc is
  // about to change, a stall means the response would have nowhere to go
  // once the hold buffer is occupied.
  assign req = rst_ni & (state_q == S_RUN) & ~stall_i & ~redirect_i;

  fetch_hold_buffer #(
    .XLEN (XLEN)
  ) u_hold (
    .clk_i        (clk_i),
    .rst_ni       (rst_ni),
    .clear_i      (hb_clear),
    .load_i       (hb_load),
    .unload_i     (hb_unload),
    .instr_i      (imem_rdata_i),
    .pc_i         (req_pc_q),
    .hold_valid_o (hold_valid),
    .instr_o      (hold_instr),
    .pc_o         (hold_pc)
  );

  always_comb begin
    state_d      = state_q;
    fpc_d        = fpc_q;
    req_pc_d     = req_pc_q;
    inflight_d   = 1'b0;
    if_id_d      = if_id_q;
    misaligned_d = misaligned_q;
    hb_load      = 1'b0;
    hb_unload    = 1'b0;
    hb_clear     = 1'b0;

    if (redirect_i) begin
      // Flush: empty IF/ID, drop the held entry, and leave inflight at 0 so
      // the response to last cycle's request is ignored next cycle.
      hb_clear         = 1'b1;
      if_id_d.valid    = 1'b0;
      if_id_d.instr    = NOP_INSTR;
      if_id_d.pc       = redirect_pc_i;
      if_id_d.pc_plus4 = redirect_pc_i + PC_INC;
      fpc_d            = redirect_pc_i;
      if (is_misaligned(redirect_pc_i[1:0])) begin
        // pc_o carries the offending target for the trap handler.
        state_d      = S_FAULT;
        misaligned_d = 1'b1;
      end else begin
        state_d      = S_RUN;
        misaligned_d = 1'b0;
      end
    end else begin
      if (req) begin
        fpc_d      = fpc_q + PC_INC;
        req_pc_d   = fpc_q;
        inflight_d = 1'b1;
      end

      if (stall_i) begin
        // IF/ID holds; a response still arriving is parked.
        hb_load = inflight_q;
      end else if (hold_valid) begin
        // Nothing can be in flight here: the previous cycle was stalled and
        // therefore issued no request.
        if_id_d.instr    = hold_instr;
        if_id_d.pc       = hold_pc;
        if_id_d.pc_plus4 = hold_pc + PC_INC;
        if_id_d.valid    = 1'b1;
        hb_unload        = 1'b1;
      end else if (inflight_q) begin
        if_id_d.instr    = imem_rdata_i;
        if_id_d.pc       = req_pc_q;
        if_id_d.pc_plus4 = req_pc_q + PC_INC;
        if_id_d.valid    = 1'b1;
      end else begin
        // Bubble: pc_o keeps its last value so a fault PC stays visible.
        if_id_d.valid = 1'b0;
        if_id_d.instr = NOP_INSTR;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q      <= S_RUN;
      fpc_q        <= RESET_PC;
      req_pc_q     <= RESET_PC;
      inflight_q   <= 1'b0;
      if_id_q      <= IF_ID_RESET;
      misaligned_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      fpc_q        <= fpc_d;
      req_pc_q     <= req_pc_d;
      inflight_q   <= inflight_d;
      if_id_q      <= if_id_d;
      misaligned_q <= misaligned_d;
    end
  end

  assign imem_req_o   = req;
  assign imem_addr_o  = fpc_q;
  assign instr_o      = if_id_q.instr;
  assign pc_o         = if_id_q.pc;
  assign pc_plus4_o   = if_id_q.pc_plus4;
  assign valid_o      = if_id_q.valid;
  assign misaligned_o = misaligned_q;

endmodule

// File: tb/tb_fetch_unit.sv
// -----------------------------------------------------------------------------
// tb_fetch_unit
//   Directed cycle-exact scenarios followed by a long randomized run. The
//   reference model tracks the program-order stream: the next PC the decoder
//   must receive, the next address that must be requested, and whether the
//   unit is parked on a misaligned target. A second instance with a reset PC
//   near the top of the address space covers PC wrap-around.
// -----------------------------------------------------------------------------
module tb_fetch_unit;

  localparam logic [31:0] NOP      = 32'h0000_0013;
  localparam logic [31:0] RST_PC   = 32'h0000_0000;
  localparam logic [31:0] W_RST_PC = 32'hFFFF_FFF8;

  // ---------------- clock / reset / signals ----------------
  logic        clk;
  logic        rst_n;
  logic        stall, redirect;
  logic [31:0] redirect_pc;
  logic        imem_req;
  logic [31:0] imem_addr, imem_rdata;
  logic [31:0] instr, pc, pc_plus4;
  logic        valid, misaligned;

  logic        w_stall, w_redirect;
  logic [31:0] w_redirect_pc;
  logic        w_imem_req;
  logic [31:0] w_imem_addr, w_imem_rdata;
  logic [31:0] w_instr, w_pc, w_pc_plus4;
  logic        w_valid, w_misaligned;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  fetch_unit #(.XLEN(32), .RESET_PC(RST_PC)) dut (
    .clk_i(clk), .rst_ni(rst_n), .stall_i(stall), .redirect_i(redirect),
    .redirect_pc_i(redirect_pc), .imem_req_o(imem_req), .imem_addr_o(imem_addr),
    .imem_rdata_i(imem_rdata), .instr_o(instr), .pc_o(pc), .pc_plus4_o(pc_plus4),
    .valid_o(valid), .misaligned_o(misaligned)
  );

  fetch_unit #(.XLEN(32), .RESET_PC(W_RST_PC)) dut_wrap (
    .clk_i(clk), .rst_ni(rst_n), .stall_i(w_stall), .redirect_i(w_redirect),
    .redirect_pc_i(w_redirect_pc), .imem_req_o(w_imem_req), .imem_addr_o(w_imem_addr),
    .imem_rdata_i(w_imem_rdata), .instr_o(w_instr), .pc_o(w_pc), .pc_plus4_o(w_pc_plus4),
    .valid_o(w_valid), .misaligned_o(w_misaligned)
  );

  // Instruction memory contents as a function of address.
  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return a ^ 32'hA5A5_0000;
  endfunction

  // Synchronous 1-cycle memories; garbage when no request was made.
  always @(posedge clk) begin
    imem_rdata   <= imem_req   ? mem_word(imem_addr)   : $urandom;
    w_imem_rdata <= w_imem_req ? mem_word(w_imem_addr) : $urandom;
  end

  // ---------------- scoreboard ----------------
  int n_checks = 0;
  int n_fail   = 0;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // Reference model state
  bit          m_live     = 0;
  bit          m_fault    = 0;
  logic [31:0] m_fault_pc = '0;
  logic [31:0] m_next     = RST_PC;  // next PC the decoder must consume
  logic [31:0] m_fetch    = RST_PC;  // next address that must be requested
  int          m_gap      = 0;
  int          m_consumed = 0;
  logic [31:0] exp_q[$];             // consumed PCs awaiting comparison

  task automatic model_cycle();
    logic exp_req;
    logic consumed;
    logic [31:0] e;
    check_eq("misaligned", {31'd0, misaligned}, {31'd0, m_fault});
    check_eq("pc_plus4", pc_plus4, pc + 32'd4);
    if (!valid) check_eq("nop_when_invalid", instr, NOP);
    if (m_fault) begin
      check_eq("fault_valid", {31'd0, valid}, 32'd0);
      check_eq("fault_pc", pc, m_fault_pc);
    end
    exp_req = rst_n & ~m_fault & ~stall & ~redirect;
    check_eq("req", {31'd0, imem_req}, {31'd0, exp_req});
    if (imem_req && exp_req) check_eq("fetch_addr", imem_addr, m_fetch);

    consumed = rst_n & valid & ~stall & ~redirect;
    if (consumed) begin
      exp_q.push_back(m_next);
      m_next = m_next + 32'd4;
      m_consumed++;
      e = exp_q.pop_front();
      check_eq("stream_pc", pc, e);
      check_eq("stream_instr", instr, mem_word(e));
    end

    if (!rst_n || redirect || stall || m_fault || consumed) m_gap = 0;
    else begin
      m_gap++;
      check_eq("progress", {31'd0, (m_gap <= 2)}, 32'd1);
    end

    if (!rst_n) begin
      m_fault = 0;
      m_next  = RST_PC;
      m_fetch = RST_PC;
      exp_q.delete();
    end else if (redirect) begin
      if (redirect_pc[1:0] != 2'b00) begin
        m_fault    = 1;
        m_fault_pc = redirect_pc;
      end else begin
        m_fault = 0;
        m_next  = redirect_pc;
        m_fetch = redirect_pc;
      end
    end else if (exp_req) begin
      m_fetch = m_fetch + 32'd4;
    end
  endtask

  // ---------------- driver ----------------
  // One clock cycle: apply inputs shortly after the edge, let outputs settle,
  // then run the model against this cycle's inputs and outputs.
  task automatic step(input logic r, input logic s, input logic rd, input logic [31:0] rp);
    @(posedge clk);
    #1;
    rst_n       = r;
    stall       = s;
    redirect    = rd;
    redirect_pc = rp;
    #1;
    if (m_live) model_cycle();
    if (!r) m_live = 1;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    rst_n = 1'b0; stall = 1'b0; redirect = 1'b0; redirect_pc = '0;
    w_stall = 1'b0; w_redirect = 1'b0; w_redirect_pc = '0;

    step(0, 0, 0, 0);
    step(0, 0, 0, 0);

    // Reset release and steady-state streaming
    step(1, 0, 0, 0);  // cycle 0
    check_eq("rst_valid", {31'd0, valid}, 32'd0);
    check_eq("rst_instr", instr, NOP);
    check_eq("rst_pc", pc, 32'd0);
    check_eq("rst_misaligned", {31'd0, misaligned}, 32'd0);
    check_eq("c0_req", {31'd0, imem_req}, 32'd1);
    check_eq("c0_addr", imem_addr, RST_PC);
    check_eq("w_c0_addr", w_imem_addr, W_RST_PC);
    step(1, 0, 0, 0);  // cycle 1
    check_eq("c1_valid", {31'd0, valid}, 32'd0);
    step(1, 0, 0, 0);  // cycle 2
    check_eq("c2_valid", {31'd0, valid}, 32'd1);
    check_eq("c2_pc", pc, 32'h0);
    check_eq("c2_instr", instr, mem_word(32'h0));
    check_eq("w_c2_pc", w_pc, 32'hFFFF_FFF8);
    check_eq("w_c2_addr_wrap", w_imem_addr, 32'h0);
    step(1, 0, 0, 0);  // cycle 3
    check_eq("c3_pc", pc, 32'h4);
    check_eq("w_c3_pc", w_pc, 32'hFFFF_FFFC);
    check_eq("w_c3_pc_plus4", w_pc_plus4, 32'h0);

    // Three-cycle stall while pc_o = 8
    for (int i = 0; i < 3; i++) begin
      step(1, 1, 0, 0);
      check_eq("stall_pc", pc, 32'h8);
      check_eq("stall_req", {31'd0, imem_req}, 32'd0);
      if (i == 0) check_eq("w_c4_pc", w_pc, 32'h0);
    end
    step(1, 0, 0, 0);
    check_eq("release_pc", pc, 32'h8);
    step(1, 0, 0, 0);
    check_eq("release_pc_c", pc, 32'hC);
    step(1, 0, 0, 0);
    check_eq("release_pc_10", pc, 32'h10);
    for (int i = 0; i < 3; i++) step(1, 0, 0, 0);

    // Redirect to 0x100 while stalled on pc_o = 0x20, with 0x24 held
    step(1, 1, 0, 0);
    check_eq("pre_redir_pc", pc, 32'h20);
    step(1, 1, 1, 32'h100);  // R
    check_eq("redir_req", {31'd0, imem_req}, 32'd0);
    step(1, 0, 0, 0);        // R+1
    check_eq("r1_valid", {31'd0, valid}, 32'd0);
    check_eq("r1_req", {31'd0, imem_req}, 32'd1);
    check_eq("r1_addr", imem_addr, 32'h100);
    step(1, 0, 0, 0);        // R+2
    check_eq("r2_valid", {31'd0, valid}, 32'd0);
    step(1, 0, 0, 0);        // R+3
    check_eq("r3_valid", {31'd0, valid}, 32'd1);
    check_eq("r3_pc", pc, 32'h100);

    // Misaligned redirect, then recovery to 0x200
    step(1, 0, 1, 32'h102);  // M
    for (int i = 0; i < 3; i++) begin
      step(1, 0, 0, 0);
      check_eq("fault_misaligned", {31'd0, misaligned}, 32'd1);
      check_eq("fault_req", {31'd0, imem_req}, 32'd0);
      check_eq("fault_pc_o", pc, 32'h102);
    end
    step(1, 0, 1, 32'h200);  // A
    step(1, 0, 0, 0);        // A+1
    check_eq("a1_misaligned", {31'd0, misaligned}, 32'd0);
    check_eq("a1_addr", imem_addr, 32'h200);
    step(1, 0, 0, 0);        // A+2
    step(1, 0, 0, 0);        // A+3
    check_eq("a3_valid", {31'd0, valid}, 32'd1);
    check_eq("a3_pc", pc, 32'h200);

    // Reset during a stall with an occupied hold buffer
    step(1, 0, 0, 0);
    step(1, 0, 0, 0);
    step(1, 1, 0, 0);        // in-flight response parked
    step(0, 1, 0, 0);        // reset wins
    step(1, 0, 0, 0);
    check_eq("mid_rst_valid", {31'd0, valid}, 32'd0);
    check_eq("mid_rst_instr", instr, NOP);
    check_eq("mid_rst_addr", imem_addr, RST_PC);
    step(1, 0, 0, 0);
    step(1, 0, 0, 0);
    check_eq("restart_pc", pc, RST_PC);
    check_eq("restart_valid", {31'd0, valid}, 32'd1);

    // Randomized run against the stream model
    for (int i = 0; i < 4000; i++) begin
      logic r, s, rd;
      logic [31:0] rp;
      r  = ($urandom_range(0, 299) != 0);
      s  = ($urandom_range(0, 3) == 0);
      rd = ($urandom_range(0, 19) == 0);
      case ($urandom_range(0, 7))
        0:       rp = 32'hFFFF_FFF0;
        1:       rp = ($urandom & 32'h0000_0FFC) | 32'($urandom_range(1, 3));
        default: rp = $urandom & 32'h0000_0FFC;
      endcase
      step(r, s, rd, rp);
    end
    check_eq("made_progress", {31'd0, (m_consumed > 1000)}, 32'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/fetch_unit.md
Name: fetch_unit

Overview:
- Instruction fetch stage directly upstream of the control unit decoder.
- Holds the fetch PC and issues word requests to a fixed 1-cycle-latency synchronous instruction memory.
- Registers each returned instruction, with its PC and PC+4, into the IF/ID output register; the decoder takes opcode from instr_o[6:0].
- Supports decode-side stall (one-entry hold buffer), redirect for taken branch/jump, and misaligned-target fault.

Parameters:
- XLEN, 32, width of PC, address and instruction.
- RESET_PC, 32'h0000_0000, first fetch address after reset.

Ports:
- clk_i  input  1  clock; all state updates on rising edge.
- rst_ni  input  1  synchronous active-low reset.
- stall_i  input  1  decode cannot accept; hold IF/ID contents.
- redirect_i  input  1  taken branch/jump; discard all fetched-but-unconsumed work.
- redirect_pc_i  input  XLEN  target PC, valid when redirect_i=1.
- imem_req_o  output  1  read request this cycle.
- imem_addr_o  output  XLEN  request address; equals fetch PC.
- imem_rdata_i  input  XLEN  instruction for the request issued in the previous cycle.
- instr_o  output  XLEN  IF/ID instruction; NOP when valid_o=0.
- pc_o  output  XLEN  PC of instr_o.
- pc_plus4_o  output  XLEN  pc_o+4, mod 2^XLEN.
- valid_o  output  1  instr_o/pc_o hold a real instruction.
- misaligned_o  output  1  high while in S_FAULT.

Behaviour:
- Reset (rst_ni=0 at an edge):
  - fpc<=RESET_PC; state<=S_RUN.
  - Clear valid_o, inflight and hold_valid.
  - instr_o<=NOP (32'h0000_0013); pc_o<=0; misaligned_o<=0.
  - A reset asserted mid-stall or mid-redirect wins over every other input.
- Request:
  - imem_req_o = rst_ni & (state==S_RUN) & ~stall_i & ~redirect_i.
  - imem_addr_o = fpc.
  - On a request, fpc<=fpc+4 (wraps 0xFFFF_FFFC -> 0) and inflight<=1; otherwise inflight<=0.
- Response (inflight=1): imem_rdata_i pairs with the PC requested last cycle (kept in a req_pc register).
  - If stall_i=0: load it into IF/ID; valid_o=1 next cycle.
  - If stall_i=1: load it into the hold buffer (hold_valid<=1).
- Latency:
  - First request in the first cycle after reset release (cycle 0); valid_o=1 with pc_o=RESET_PC in cycle 2.
  - Steady state: one instruction per cycle.
- Stall:
  - While stall_i=1: IF/ID holds; no request; fpc holds.
  - On the first cycle with stall_i=0 and hold_valid=1: IF/ID<=hold and hold_valid<=0; a new request issues in the same cycle.
  - No instruction is lost or duplicated.
- Redirect (priority over stall, below reset):
  - valid_o<=0 and instr_o<=NOP; hold_valid<=0; inflight<=0, so the response arriving next cycle is dropped.
  - If redirect_pc_i[1:0]==0: fpc<=redirect_pc_i and state stays S_RUN. The first request is at R+1; valid_o=1 at R+3 for redirect cycle R.
  - If redirect_pc_i[1:0]!=0: state<=S_FAULT and misaligned_o<=1. fpc<=redirect_pc_i and pc_o<=redirect_pc_i for the trap handler.
- FSM:
  - S_RUN: S_FAULT on a misaligned redirect.
  - S_FAULT: no requests, valid_o=0. Leaves only on an aligned redirect (back to S_RUN, behaving as a normal redirect) or on reset.
- valid_o=0 implies instr_o=NOP, so the decoder's default branch is never required for safety.

Decomposition:
- Package fetch_pkg:
  - fetch_state_t enum {S_RUN, S_FAULT}.
  - NOP_INSTR = 32'h0000_0013.
  - DEFAULT_RESET_PC.
  - Typedef if_id_t {instr, pc, pc_plus4, valid}.
- Sub-module fetch_hold_buffer: one-entry hold register with load, unload and clear. Its hold_valid is exposed to the parent.

Test Plan:
- Reset release with imem returning addr-as-data -> valid_o rises in cycle 2 with pc_o=0, then pc_o=4, 8, 12 on consecutive cycles; pc_plus4_o=pc_o+4.
- stall_i high for 3 cycles while pc_o=0x8 -> pc_o stays 0x8 and imem_req_o=0 for all 3 cycles; on release pc_o=0xC then 0x10, no gap, no repeat.
- redirect_i with redirect_pc_i=0x100 while pc_o=0x20 and stall_i=1 -> valid_o=0 next cycle; imem_addr_o=0x100 at R+1; valid_o with pc_o=0x100 at R+3; held 0x24 never emitted.
- redirect_pc_i=0x102 -> misaligned_o=1, imem_req_o=0 until a redirect to 0x200; then misaligned_o=0 and pc_o=0x200 three cycles later.
- RESET_PC=32'hFFFF_FFF8, run unstalled -> pc_o sequence 0xFFFF_FFF8, 0xFFFF_FFFC, 0x0; pc_plus4_o=0x0 when pc_o=0xFFFF_FFFC.
- rst_ni=0 for one cycle during a stall with hold_valid=1 -> valid_o=0, instr_o=NOP; afterwards fetch restarts at RESET_PC with the held instruction never emitted.
